// File: rtl/pc_sequencer.sv
// Instruction sequencer that steers an external free-running program counter.
// Supports NOP/JMP/BRZ/CALL/RET/HALT with a small return-address stack and a sticky fault flag.
module pc_sequencer #(
    parameter int STACK_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [15:0]                    pc_q,
    input  logic                           instr_valid,
    input  logic [2:0]                     op,
    input  logic [15:0]                    target,
    input  logic                           cond,
    output logic                           pc_load,
    output logic [15:0]                    pc_datain,
    output logic                           fetch_req,
    output logic                           busy,
    output logic                           halted,
    output logic                           err,
    output logic [$clog2(STACK_DEPTH):0]   sp
);

    localparam int AW  = $clog2(STACK_DEPTH);
    localparam int SPW = AW + 1;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_BRZ  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_HALT
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [2:0]  op_r;
    logic [15:0] target_r;
    logic        cond_r;
    logic [15:0] stack [STACK_DEPTH];

    logic            stack_full;
    logic            stack_empty;
    logic [SPW-1:0]  sp_dec;
    logic [AW-1:0]   push_idx;
    logic [AW-1:0]   pop_idx;
    logic [15:0]     stack_top;
    logic [15:0]     return_addr;
    logic            do_push;
    logic            do_pop;
    logic            fault;
    logic            halt_op;

    assign stack_full  = (sp == SPW'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    assign sp_dec      = sp - SPW'(1);
    assign push_idx    = sp[AW-1:0];
    assign pop_idx     = sp_dec[AW-1:0];
    assign stack_top   = stack[pop_idx];
    assign return_addr = pc_q + 16'd1;

    // Stack actions and faults only ever happen in the single EXEC cycle.
    always_comb begin
        do_push = 1'b0;
        do_pop  = 1'b0;
        fault   = 1'b0;
        halt_op = 1'b0;
        if (state == S_EXEC) begin
            case (op_r)
                OP_NOP, OP_JMP, OP_BRZ: ;
                OP_CALL: begin
                    do_push = !stack_full;
                    fault   = stack_full;
                end
                OP_RET: begin
                    do_pop = !stack_empty;
                    fault  = stack_empty;
                end
                OP_HALT: halt_op = 1'b1;
                default: fault = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_FETCH;
            S_FETCH: next_state = S_WAIT;
            S_WAIT:  if (instr_valid) next_state = S_EXEC;
            S_EXEC:  next_state = (fault || halt_op) ? S_HALT : S_FETCH;
            S_HALT:  if (start && !err) next_state = S_FETCH;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        pc_load   = 1'b1;
        pc_datain = pc_q;
        fetch_req = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        case (state)
            S_FETCH: begin
                fetch_req = 1'b1;
                busy      = 1'b1;
            end
            S_WAIT: busy = 1'b1;
            S_EXEC: begin
                busy = 1'b1;
                case (op_r)
                    OP_NOP: pc_load = 1'b0;
                    OP_JMP: pc_datain = target_r;
                    OP_BRZ: begin
                        pc_load   = cond_r;
                        pc_datain = cond_r ? target_r : pc_q;
                    end
                    OP_CALL: if (!stack_full)  pc_datain = target_r;
                    OP_RET:  if (!stack_empty) pc_datain = stack_top;
                    default: pc_datain = pc_q;
                endcase
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    // Instruction fields are latched only when WAIT accepts an instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r     <= OP_NOP;
            target_r <= 16'h0000;
            cond_r   <= 1'b0;
        end else if (state == S_WAIT && instr_valid) begin
            op_r     <= op;
            target_r <= target;
            cond_r   <= cond;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp  <= '0;
            err <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack[i] <= 16'h0000;
            end
        end else begin
            if (do_push) begin
                stack[push_idx] <= return_addr;
                sp              <= sp + SPW'(1);
            end else if (do_pop) begin
                sp <= sp_dec;
            end
            if (fault) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: STACK_DEPTH, default 4, number of return-address stack entries (power of two, 2..16).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 Port: start  input  1  begin/resume sequencing; sampled in IDLE and HALT only.
REQ-005 Port: pc_q  input  16  current value of the 16-bit program counter.
REQ-006 Port: instr_valid  input  1  op/target/cond valid this cycle; sampled in WAIT only.
REQ-007 Port: op  input  3  opcode: 000 NOP, 001 JMP, 010 BRZ, 011 CALL, 100 RET, 101 HALT, 110/111 illegal.
REQ-008 Port: target  input  16  jump/branch/call destination.
REQ-009 Port: cond  input  1  branch condition for BRZ (taken when 1).
REQ-010 Port: pc_load  output  1  drives the counter's load input.
REQ-011 Port: pc_datain  output  16  drives the counter's datain input.
REQ-012 Port: fetch_req  output  1  one-cycle instruction-fetch strobe at address pc_q.
REQ-013 Port: busy  output  1  high in FETCH, WAIT, EXEC.
REQ-014 Port: halted  output  1  high in HALT.
REQ-015 Port: err  output  1  sticky error flag (stack overflow, underflow, illegal op).
REQ-016 Port: sp  output  log2(STACK_DEPTH)+1  current stack occupancy.

Function
REQ-017 The counter increments every cycle unless loaded; the block SHALL therefore hold the PC by asserting pc_load=1 with pc_datain=pc_q in IDLE, FETCH, WAIT, HALT.
REQ-018 FSM states SHALL be IDLE, FETCH, WAIT, EXEC, HALT; outputs Moore-decoded from state, captured op fields, pc_q and stack top.
REQ-019 IDLE: start=1 -> FETCH; else stay.
REQ-020 FETCH: fetch_req=1 for exactly one cycle; always -> WAIT.
REQ-021 WAIT: on instr_valid=1, capture op, target, cond into registers -> EXEC; else stay (no timeout).
REQ-022 EXEC lasts one cycle; next state FETCH except HALT/error cases below.
REQ-023 EXEC NOP: pc_load=0 (counter increments).
REQ-024 EXEC JMP: pc_load=1, pc_datain=target.
REQ-025 EXEC BRZ: cond=1 -> load target; cond=0 -> pc_load=0.
REQ-026 EXEC CALL, stack not full: push pc_q+1 (16-bit wrap, FFFF -> 0000), load target, sp+1.
REQ-027 EXEC RET, stack not empty: pop, load popped address, sp-1.
REQ-028 EXEC HALT op: hold PC (pc_load=1, pc_datain=pc_q) -> HALT.
REQ-029 CALL on full stack, RET on empty stack, or illegal op: hold PC, stack unchanged, set err -> HALT.
REQ-030 HALT: hold PC; start=1 with err=0 -> FETCH; start ignored while err=1.
REQ-031 start in FETCH/WAIT/EXEC and instr_valid outside WAIT SHALL be ignored.
REQ-032 err SHALL clear only on reset.

Reset
REQ-033 On reset: state IDLE, sp=0, err=0, captured op=NOP, target=0, cond=0, stack entries 0.
REQ-034 During/after reset outputs: pc_load=1, pc_datain=pc_q, fetch_req=0, busy=0, halted=0.
REQ-035 Reset mid-operation (any state, incl. EXEC) SHALL abort immediately with no push/pop completed.

Verification
REQ-036 Reset, pc_q=0, start one cycle -> fetch_req high one cycle; NOP accepted -> EXEC pc_load=0, counter reaches 1, next fetch at 1.
REQ-037 JMP target=0x0040 -> EXEC pc_load=1, pc_datain=0x0040; BRZ cond=0 at 0x0040 -> next fetch 0x0041.
REQ-038 CALL 0x0100 at pc 0x0010, then RET -> sp 1 then 0; PC returns to 0x0011.
REQ-039 Five nested CALLs with STACK_DEPTH=4 -> fifth sets err=1, halted=1, sp=4, PC held; start ignored.
REQ-040 RET with sp=0 and separately op=111 -> err=1, HALT; HALT op alone -> halted=1, err=0, start resumes at fetch of same pc.
REQ-041 Assert reset in WAIT with instr_valid=1 and in EXEC of CALL -> IDLE, sp=0, no push, fetch_req=0.
